// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq_pkg
//   Shared definitions for the shift-and-add multiplier controller:
//   ALU opcode constants (matching the datapath ALU) and the controller
//   state encoding.
package alu_mul_seq_pkg;

  localparam logic [3:0] ALU_NOT = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_DEC = 4'b0100;
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_INC = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1011;
  localparam logic [3:0] ALU_LUI = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EVAL  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if
//   Bundles the multiplier request/response handshake and the shared-ALU
//   operand/opcode/result signals.
//   slave  : the multiplier controller (accepts start/a/b, sees alu_result,
//            drives busy/done/product and the ALU operand mux inputs)
//   master : the enclosing datapath / requester
//   Signals: start, a, b, busy, done, product,
//            alu_sel, alu_srcA, alu_srcB, alu_oper, alu_shift, alu_result
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             alu_sel;
  logic [WIDTH-1:0] alu_srcA;
  logic [WIDTH-1:0] alu_srcB;
  logic [3:0]       alu_oper;
  logic [4:0]       alu_shift;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  start, a, b, alu_result,
    output busy, done, product, alu_sel, alu_srcA, alu_srcB, alu_oper, alu_shift
  );

  modport master (
    output start, a, b, alu_result,
    input  busy, done, product, alu_sel, alu_srcA, alu_srcB, alu_oper, alu_shift
  );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
//   Multi-cycle shift-and-add multiplier that borrows the shared datapath
//   ALU. Produces the low WIDTH bits of a*b using only ALU ADD (accumulate)
//   and SLL (shift multiplicand). Early exit ends the run as soon as the
//   remaining multiplier bits are all zero (when EARLY_EXIT=1).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_mul_seq_if.slave: start/a/b in, busy/done/product out,
//            alu_sel/alu_srcA/alu_srcB/alu_oper/alu_shift out, alu_result in
//   All outputs are registered; each transition loads the output values
//   belonging to the state being entered.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  alu_mul_seq_if.slave bus
);

  localparam int                CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH);

  mul_state_t       state;
  logic [WIDTH-1:0] m;     // multiplicand, shifted left each step
  logic [WIDTH-1:0] q;     // multiplier, shifted right each step
  logic [WIDTH-1:0] p;     // accumulator
  logic [CNT_W-1:0] cnt;   // bits processed so far

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      m             <= '0;
      q             <= '0;
      p             <= '0;
      cnt           <= '0;
      bus.product   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.alu_sel   <= 1'b0;
      bus.alu_srcA  <= '0;
      bus.alu_srcB  <= '0;
      bus.alu_oper  <= ALU_ADD;
      bus.alu_shift <= 5'd0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            m        <= bus.a;
            q        <= bus.b;
            p        <= '0;
            cnt      <= '0;
            state    <= ST_EVAL;
            bus.busy <= 1'b1;
          end
        end

        ST_EVAL: begin
          if ((cnt == CNT_MAX) || (EARLY_EXIT && (q == '0))) begin
            // P is stable here, so the result is presented together with done.
            state       <= ST_DONE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.product <= p;
          end else if (q[0]) begin
            state         <= ST_ADD;
            bus.alu_sel   <= 1'b1;
            bus.alu_srcA  <= p;
            bus.alu_srcB  <= m;
            bus.alu_oper  <= ALU_ADD;
            bus.alu_shift <= 5'd0;
          end else begin
            state         <= ST_SHIFT;
            bus.alu_sel   <= 1'b1;
            bus.alu_srcA  <= '0;
            bus.alu_srcB  <= m;
            bus.alu_oper  <= ALU_SLL;
            bus.alu_shift <= 5'd1;
          end
        end

        ST_ADD: begin
          // M is untouched in ADD, so it is still valid as the SHIFT operand.
          p             <= bus.alu_result;
          state         <= ST_SHIFT;
          bus.alu_srcA  <= '0;
          bus.alu_srcB  <= m;
          bus.alu_oper  <= ALU_SLL;
          bus.alu_shift <= 5'd1;
        end

        ST_SHIFT: begin
          m             <= bus.alu_result;
          q             <= q >> 1;
          cnt           <= cnt + 1'b1;
          state         <= ST_EVAL;
          bus.alu_sel   <= 1'b0;
          bus.alu_srcA  <= '0;
          bus.alu_srcB  <= '0;
          bus.alu_oper  <= ALU_ADD;
          bus.alu_shift <= 5'd0;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state         <= ST_IDLE;
          bus.busy      <= 1'b0;
          bus.alu_sel   <= 1'b0;
          bus.alu_srcA  <= '0;
          bus.alu_srcB  <= '0;
          bus.alu_oper  <= ALU_ADD;
          bus.alu_shift <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq
//   Bench for alu_mul_seq: one instance with early exit, one without, each
//   paired with a behavioural model of the shared ALU (alu_sel tied on).
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        sel = 1'b0;     // 0: early-exit DUT, 1: full-length DUT
  logic [31:0] a_drv = '0;
  logic [31:0] b_drv = '0;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_mul_seq_if #(.WIDTH(32)) ee_if ();
  alu_mul_seq_if #(.WIDTH(32)) fx_if ();

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] sh);
    case (op)
      ALU_NOT: alu_f = ~x;
      ALU_AND: alu_f = x & y;
      ALU_XOR: alu_f = x ^ y;
      ALU_OR:  alu_f = x | y;
      ALU_DEC: alu_f = x - 32'd1;
      ALU_ADD: alu_f = x + y;
      ALU_SUB: alu_f = x - y;
      ALU_INC: alu_f = x + 32'd1;
      ALU_SLT: alu_f = {31'd0, $signed(x) < $signed(y)};
      ALU_SLL: alu_f = y << sh;
      ALU_SRL: alu_f = y >> sh;
      ALU_LUI: alu_f = {y[15:0], 16'h0000};
      default: alu_f = 32'd0;
    endcase
  endfunction

  assign ee_if.start      = go & ~sel;
  assign ee_if.a          = a_drv;
  assign ee_if.b          = b_drv;
  assign ee_if.alu_result = alu_f(ee_if.alu_oper, ee_if.alu_srcA, ee_if.alu_srcB, ee_if.alu_shift);
  assign fx_if.start      = go & sel;
  assign fx_if.a          = a_drv;
  assign fx_if.b          = b_drv;
  assign fx_if.alu_result = alu_f(fx_if.alu_oper, fx_if.alu_srcA, fx_if.alu_srcB, fx_if.alu_shift);

  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_ee (.clk(clk), .rst_n(rst_n), .bus(ee_if.slave));
  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_fx (.clk(clk), .rst_n(rst_n), .bus(fx_if.slave));

  wire        done_m    = sel ? fx_if.done    : ee_if.done;
  wire        busy_m    = sel ? fx_if.busy    : ee_if.busy;
  wire        alusel_m  = sel ? fx_if.alu_sel : ee_if.alu_sel;
  wire [31:0] product_m = sel ? fx_if.product : ee_if.product;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Done cycle from the operand: 2k+s+2 with early exit, 2*32+s+2 without.
  function automatic int exp_cycles(input logic [31:0] bv, input bit full);
    int k = 0;
    int s = 0;
    for (int i = 0; i < 32; i++) begin
      if (bv[i]) begin
        k = i + 1;
        s++;
      end
    end
    exp_cycles = full ? (64 + s + 2) : (2 * k + s + 2);
  endfunction

  // Called just after a falling edge. Start is high in cycle 0.
  task automatic run(input bit s, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] exp_p, input int exp_c, input bit chk_nosel);
    exp_t e;
    exp_t got;
    bit   seen_sel = 1'b0;
    bit   finished = 1'b0;
    sel   = s;
    a_drv = av;
    b_drv = bv;
    e.prod = exp_p;
    e.cyc  = exp_c;
    exp_q.push_back(e);
    go = 1'b1;
    @(posedge clk);
    #1;
    go    = 1'b0;
    a_drv = ~av;      // later operand changes must not matter
    b_drv = ~bv;
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("busy_c1", {63'd0, busy_m}, 64'd1);
      if (alusel_m) seen_sel = 1'b1;
      if (done_m) begin
        finished = 1'b1;
        got = exp_q.pop_front();
        check("product", {32'd0, product_m}, {32'd0, got.prod});
        check("done_cycle", 64'(cyc), 64'(got.cyc));
        check("busy_at_done", {63'd0, busy_m}, 64'd0);
      end
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL timeout observed=no_done expected=done_in_cycle_%0d", exp_c);
      void'(exp_q.pop_front());
    end
    if (chk_nosel) check("alu_sel_never", {63'd0, seen_sel}, 64'd0);
    @(negedge clk);
    check("done_pulse_1cyc", {63'd0, done_m}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          aborted_done;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",    {63'd0, ee_if.busy}, 64'd0);
    check("rst_done",    {63'd0, ee_if.done}, 64'd0);
    check("rst_product", {32'd0, ee_if.product}, 64'd0);
    check("rst_alu_sel", {63'd0, ee_if.alu_sel}, 64'd0);
    check("rst_alu_oper", {60'd0, ee_if.alu_oper}, 64'h5);
    check("rst_fx_product", {32'd0, fx_if.product}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start_busy", {63'd0, ee_if.busy}, 64'd0);

    // Directed cases
    run(1'b0, 32'd5, 32'd1, 32'd5, 5, 1'b0);
    run(1'b0, 32'h1234, 32'd0, 32'd0, 2, 1'b1);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 98, 1'b0);
    run(1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 37, 1'b0);
    run(1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 67, 1'b0);

    // Random operands, varying multiplier length
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom & (32'hFFFF_FFFF >> $urandom_range(31, 0));
      run(i[0], ra, rb, ra * rb, exp_cycles(rb, i[0]), 1'b0);
    end

    // Re-pulsed start is ignored, then an asynchronous reset aborts the run
    sel = 1'b0;
    a_drv = 32'd3;
    b_drv = 32'd7;
    aborted_done = 1'b0;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      if (done_m) aborted_done = 1'b1;
      if (cyc == 3) begin
        a_drv = 32'd9;
        b_drv = 32'd9;
        go = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    go = 1'b0;
    check("repulse_busy", {63'd0, busy_m}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy",    {63'd0, busy_m}, 64'd0);
    check("abort_done",    {63'd0, done_m}, 64'd0);
    check("abort_product", {32'd0, product_m}, 64'd0);
    check("abort_alu_sel", {63'd0, alusel_m}, 64'd0);
    check("abort_no_done", {63'd0, aborted_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 32'd6, 32'd7, 32'd42, 11, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle shift-and-add multiplier controller that sequences the shared 32-bit combinational ALU. It produces the low WIDTH bits of a×b using only the ALU's ADD and shift-left operations. It sits beside the ALU in the datapath and drives the ALU operand/opcode mux while a multiply is in progress. Latency depends on the operand, with early exit when the remaining multiplier bits are zero.

## Interface
- WIDTH, 32, operand/product width; must match ALU width
- EARLY_EXIT, 1, 1 = finish when remaining multiplier is 0; 0 = always process WIDTH bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  multiplicand, latched on accepted start
- b  in  WIDTH  multiplier, latched on accepted start
- busy  out  1  high in EVAL/ADD/SHIFT
- done  out  1  one-cycle pulse in DONE state
- product  out  WIDTH  registered result (a×b mod 2^WIDTH); holds until next completion
- alu_sel  out  1  high in ADD/SHIFT: datapath mux gives ALU inputs to this block
- alu_srcA  out  WIDTH  ALU operand A
- alu_srcB  out  WIDTH  ALU operand B
- alu_oper  out  4  ALU opcode
- alu_shift  out  5  ALU shift amount
- alu_result  in  WIDTH  combinational ALU result, same cycle

## Operation
- Internal registers: M (multiplicand), Q (multiplier), P (accumulator), cnt (0..WIDTH, $clog2(WIDTH)+1 bits).
- IDLE: on start=1, latch M=a, Q=b, P=0, cnt=0, then go to EVAL. Otherwise stay.
- EVAL:
  - If cnt==WIDTH, or EARLY_EXIT and Q==0, go to DONE.
  - Else if Q[0], go to ADD.
  - Else go to SHIFT.
- ADD: drive oper=4'b0101, srcA=P, srcB=M. Set P<=alu_result. Go to SHIFT.
- SHIFT: drive oper=4'b1010, srcB=M, shift=1. Set M<=alu_result, Q<=Q>>1 (internal, not via ALU), cnt<=cnt+1. Go to EVAL.
- DONE: product<=P, done=1. Go to IDLE.
- ALU outputs outside ADD/SHIFT: srcA=0, srcB=0, oper=4'b0101, shift=0. In SHIFT, srcA=0.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag. Bits shifted out of M are discarded.
- start in any state other than IDLE (including DONE) is ignored, not queued.
- a/b changes after acceptance have no effect.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE; M, Q, P, cnt, product = 0; busy=0, done=0, alu_sel=0, ALU outputs at idle values.
- Reset mid-operation aborts: no done pulse, product is cleared to 0.
- All state and outputs are registered or decoded from state. ALU result is captured at the end of the same cycle.
- Start accepted in cycle 0 → EVAL in cycle 1.
- With EARLY_EXIT=1: let k = index of highest set bit of b plus 1 (k=0 for b=0), s = popcount(b). done is high in cycle 2k+s+2.
- With EARLY_EXIT=0: done is high in cycle 2·WIDTH+s+2.
- busy is high in cycles 1 .. (done cycle − 1). Earliest next start is accepted the cycle after done.
- Maximum latency (b all ones, WIDTH=32): 98 cycles.

## Structure
- Shared package/header alu_defs: ALU opcode constants (ALU_NOT=0000, ALU_AND=0001, ALU_XOR=0010, ALU_OR=0011, ALU_DEC=0100, ALU_ADD=0101, ALU_SUB=0110, ALU_INC=0111, ALU_SLT=1000, ALU_SLL=1010, ALU_SRL=1011, ALU_LUI=1100) and the state encoding (IDLE, EVAL, ADD, SHIFT, DONE; 3 bits).
- No sub-module inside alu_mul_seq. The ALU is instantiated by the enclosing datapath, which muxes alu_src*/alu_oper/alu_shift in when alu_sel=1.
- The test bench instantiates alu_mul_seq plus the ALU with alu_sel tied on.

## Test plan
- Reset asserted, no start → busy=0, done=0, product=0, alu_sel=0, alu_oper=0101.
- a=5, b=1 → states EVAL/ADD/SHIFT/EVAL/DONE; done high in cycle 5; product=5.
- a=0x1234, b=0 → done in cycle 2, product=0, alu_sel never high.
- a=0xFFFFFFFF, b=0xFFFFFFFF → done in cycle 98, product=0x00000001.
- a=0x00010000, b=0x00010000 → product=0 (wrap); done in cycle 37. Same with EARLY_EXIT=0 → done in cycle 67.
- a=3, b=7, start re-pulsed in cycle 3 → ignored; then rst_n low in cycle 4 → immediate IDLE, product=0, no done. A new start with a=6, b=7 → product=42 in cycle 11.
